// File: rtl/pinball_pkg.sv
// Shared pinball definitions: life controller state encoding and default game constants.
package pinball_pkg;

  localparam int unsigned DefaultInitialLife   = 3;
  localparam int unsigned DefaultMaxLife       = 9;
  localparam int unsigned DefaultRespawnFrames = 60;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPlay,
    StOver
  } life_state_e;

endpackage

// File: rtl/respawn_timer.sv
// Frame-counting delay between ball loss and re-serve.
// done_o is high while one frame remains, so the caller fires on the tick that expires it.
module respawn_timer #(
  parameter int unsigned Frames = 60
) (
  input  logic clk,
  input  logic resetN,
  input  logic load_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int unsigned Width = $clog2(Frames + 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = Width'(Frames);
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == Width'(1));

endmodule

// File: rtl/life_controller.sv
// Pinball life bookkeeping: serves the ball after a frame delay, counts lost balls and bonuses,
// and ends the game when the last life is lost.
module life_controller
  import pinball_pkg::*;
#(
  parameter int unsigned INITIAL_LIFE   = DefaultInitialLife,
  parameter int unsigned MAX_LIFE       = DefaultMaxLife,
  parameter int unsigned RESPAWN_FRAMES = DefaultRespawnFrames
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       ballLost,
  input  logic       extraLife,
  input  logic       startOfFrame,
  output logic [3:0] life,
  output logic       ballActive,
  output logic       respawn
);

  localparam logic [3:0] LifeInit = 4'(INITIAL_LIFE);
  localparam logic [3:0] LifeMax  = 4'(MAX_LIFE);

  life_state_e state_q, state_d;
  logic [3:0]  life_q, life_d;
  logic        ball_active_q, ball_active_d;
  logic        respawn_q, respawn_d;
  logic        ball_lost_q;
  logic        lost_edge;
  logic [3:0]  life_inc;
  logic        timer_load, timer_tick, timer_done;

  assign lost_edge = ballLost & ~ball_lost_q;
  assign life_inc  = (life_q < LifeMax) ? life_q + 4'd1 : LifeMax;

  respawn_timer #(
    .Frames (RESPAWN_FRAMES)
  ) u_respawn_timer (
    .clk    (clk),
    .resetN (resetN),
    .load_i (timer_load),
    .tick_i (timer_tick),
    .done_o (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    life_d     = life_q;
    respawn_d  = 1'b0;
    timer_load = 1'b0;
    timer_tick = 1'b0;
    unique case (state_q)
      StIdle: begin
        life_d = LifeInit;
        if (start) begin
          state_d    = StWait;
          timer_load = 1'b1;
        end
      end
      StWait: begin
        timer_tick = startOfFrame;
        if (extraLife) begin
          life_d = life_inc;
        end
        if (startOfFrame && timer_done) begin
          state_d   = StPlay;
          respawn_d = 1'b1;
        end
      end
      StPlay: begin
        if (lost_edge) begin
          // A bonus in the same cycle cancels the loss, so the game never ends here.
          if (extraLife) begin
            state_d    = StWait;
            timer_load = 1'b1;
          end else if (life_q >= 4'd2) begin
            life_d     = life_q - 4'd1;
            state_d    = StWait;
            timer_load = 1'b1;
          end else begin
            life_d  = 4'd0;
            state_d = StOver;
          end
        end else if (extraLife) begin
          life_d = life_inc;
        end
      end
      StOver: begin
        life_d = 4'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    ball_active_d = (state_d == StPlay);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      life_q        <= LifeInit;
      ball_active_q <= 1'b0;
      respawn_q     <= 1'b0;
      ball_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      life_q        <= life_d;
      ball_active_q <= ball_active_d;
      respawn_q     <= respawn_d;
      ball_lost_q   <= ballLost;
    end
  end

  assign life       = life_q;
  assign ballActive = ball_active_q;
  assign respawn    = respawn_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with INITIAL_LIFE=3, MAX_LIFE=9, RESPAWN_FRAMES=2.
module tb_life_controller;

  logic       clk;
  logic       resetN;
  logic       start;
  logic       ballLost;
  logic       extraLife;
  logic       startOfFrame;
  logic [3:0] life;
  logic       ballActive;
  logic       respawn;

  int unsigned n_checks;
  int unsigned n_pass;

  typedef struct packed {
    logic       start;
    logic       lost;
    logic       extra;
    logic       sof;
    logic [3:0] exp_life;
    logic       exp_active;
    logic       exp_respawn;
  } vec_t;

  vec_t vecs[$];

  life_controller #(
    .INITIAL_LIFE   (3),
    .MAX_LIFE       (9),
    .RESPAWN_FRAMES (2)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .ballLost     (ballLost),
    .extraLife    (extraLife),
    .startOfFrame (startOfFrame),
    .life         (life),
    .ballActive   (ballActive),
    .respawn      (respawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic s, input logic b, input logic e, input logic f,
                     input int l, input logic a, input logic r);
    vec_t v;
    v.start       = s;
    v.lost        = b;
    v.extra       = e;
    v.sof         = f;
    v.exp_life    = 4'(l);
    v.exp_active  = a;
    v.exp_respawn = r;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] el, input logic ea, input logic er);
    n_checks++;
    if (life === el && ballActive === ea && respawn === er) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got life=%0d ballActive=%b respawn=%b, want life=%0d ballActive=%b respawn=%b",
               name, life, ballActive, respawn, el, ea, er);
    end
  endtask

  // Drive inputs, then advance past one rising edge.
  task automatic cyc(input logic s, input logic b, input logic e, input logic f);
    start        = s;
    ballLost     = b;
    extraLife    = e;
    startOfFrame = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start        = 1'b0;
    ballLost     = 1'b0;
    extraLife    = 1'b0;
    startOfFrame = 1'b0;
    resetN       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Table: each row is one clock with its inputs and the outputs expected after that edge.
    add(0, 0, 1, 0, 3, 0, 0);  // bonus ignored in idle
    add(0, 1, 0, 0, 3, 0, 0);  // loss ignored in idle
    add(0, 0, 0, 1, 3, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0);  // enter wait, timer=2
    add(1, 0, 0, 1, 3, 0, 0);  // timer=1
    add(1, 0, 0, 0, 3, 0, 0);  // no frame, no count
    add(1, 0, 0, 1, 3, 1, 1);  // serve
    add(1, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);  // start drop has no effect
    add(0, 1, 0, 0, 2, 0, 0);  // loss edge
    for (int i = 0; i < 9; i++) add(0, 1, 0, 0, 2, 0, 0);
    add(0, 1, 0, 1, 2, 0, 0);
    add(0, 1, 0, 1, 2, 1, 1);  // serve with loss held high
    add(0, 1, 0, 0, 2, 1, 0);  // held level is not an edge
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(0, 1, 1, 0, 3, 0, 0);  // bonus + loss: net zero, back to wait
    add(0, 0, 1, 0, 4, 0, 0);  // bonus counts in wait
    add(0, 0, 0, 1, 4, 0, 0);
    add(0, 0, 0, 1, 4, 1, 1);
    for (int i = 5; i <= 9; i++) add(0, 0, 1, 0, i, 1, 0);
    add(0, 0, 1, 0, 9, 1, 0);  // saturated
    add(0, 1, 1, 0, 9, 0, 0);  // bonus + loss at ceiling

    do_reset();
    #1;
    check("reset_state", 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].start, vecs[i].lost, vecs[i].extra, vecs[i].sof);
      check($sformatf("vec%0d", i), vecs[i].exp_life, vecs[i].exp_active, vecs[i].exp_respawn);
    end

    // Losing every ball, with a cancelled loss at life=1, then game over.
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("serve_1", 4'd3, 1'b1, 1'b1);
    cyc(1, 1, 0, 0);
    check("loss_to_2", 4'd2, 1'b0, 1'b0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 0);
    check("loss_to_1", 4'd1, 1'b0, 1'b0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("serve_at_1", 4'd1, 1'b1, 1'b1);
    cyc(1, 1, 1, 0);
    check("cancel_at_1", 4'd1, 1'b0, 1'b0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("reserve_at_1", 4'd1, 1'b1, 1'b1);
    cyc(1, 1, 0, 0);
    check("game_over", 4'd0, 1'b0, 1'b0);
    cyc(1, 0, 1, 0);
    check("over_bonus", 4'd0, 1'b0, 1'b0);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("over_sticky", 4'd0, 1'b0, 1'b0);

    // Asynchronous reset with one frame left in wait.
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 1);
    check("wait_t1", 4'd4, 1'b0, 1'b0);
    resetN = 1'b0;
    #2;
    check("async_reset", 4'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    cyc(0, 0, 0, 1);
    check("no_respawn_after_reset", 4'd3, 1'b0, 1'b0);
    cyc(0, 0, 0, 1);
    check("idle_after_reset", 4'd3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
